// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Round-robin arbiter that lets two requesters share one data memory.
//   Each access is a three-state sequence: IDLE (arbitrate and latch the
//   winner) -> ACCESS (drive the memory for one cycle) -> RESP (pulse the
//   winner's ack with its read data or error flag).
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   req0/1, we0/1, addr0/1, wdata0/1  requester inputs (level request)
//   ack0/1, err0/1, rdata0/1       per-requester completion outputs
//   memAddress, memWriteData,
//   memWrite, memRead              memory drive, non-zero only in ACCESS
//   memReadData                    asynchronous memory read data
//   busy                           high whenever the FSM is not idle
module dmem_arbiter #(
    parameter int MEM_SIZE = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memWrite,
    output logic        memRead,
    input  logic [31:0] memReadData,
    output logic        busy
);

    localparam logic [31:0] MEM_WORDS = 32'(MEM_SIZE);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_reg;
    logic        last_grant_reg;
    logic        port_reg;
    logic        illegal_reg;
    logic        busy_reg;
    logic        ack0_reg, ack1_reg, err0_reg, err1_reg;
    logic [31:0] rdata0_reg, rdata1_reg;
    logic [31:0] mem_address_reg, mem_wdata_reg;
    logic        mem_write_reg, mem_read_reg;

    // Winner selection and the winner's request fields.
    logic        grant_next;
    logic        sel_we;
    logic [31:0] sel_addr, sel_wdata;
    logic        sel_legal;

    always_comb begin
        grant_next = 1'b0;
        if (req0 && req1) begin
            // Contention: the port not served last takes the slot.
            grant_next = ~last_grant_reg;
        end else if (req1) begin
            grant_next = 1'b1;
        end
        sel_we    = grant_next ? we1    : we0;
        sel_addr  = grant_next ? addr1  : addr0;
        sel_wdata = grant_next ? wdata1 : wdata0;
        sel_legal = (sel_addr[1:0] == 2'b00) &&
                    ({2'b00, sel_addr[31:2]} < MEM_WORDS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            last_grant_reg  <= 1'b1;
            port_reg        <= 1'b0;
            illegal_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            ack0_reg        <= 1'b0;
            ack1_reg        <= 1'b0;
            err0_reg        <= 1'b0;
            err1_reg        <= 1'b0;
            rdata0_reg      <= '0;
            rdata1_reg      <= '0;
            mem_address_reg <= '0;
            mem_wdata_reg   <= '0;
            mem_write_reg   <= 1'b0;
            mem_read_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req0 || req1) begin
                        state_reg       <= ACCESS;
                        busy_reg        <= 1'b1;
                        port_reg        <= grant_next;
                        last_grant_reg  <= grant_next;
                        illegal_reg     <= ~sel_legal;
                        // Memory strobes are prepared here so they are
                        // registered outputs for exactly the ACCESS cycle;
                        // an illegal request never strobes the memory.
                        mem_address_reg <= sel_addr;
                        mem_read_reg    <= sel_legal && !sel_we;
                        mem_write_reg   <= sel_legal && sel_we;
                        mem_wdata_reg   <= (sel_legal && sel_we) ? sel_wdata : '0;
                    end
                end
                ACCESS: begin
                    state_reg       <= RESP;
                    mem_address_reg <= '0;
                    mem_wdata_reg   <= '0;
                    mem_write_reg   <= 1'b0;
                    mem_read_reg    <= 1'b0;
                    // mem_read_reg is high only for a legal read, so it
                    // doubles as the "capture read data" select.
                    if (port_reg) begin
                        ack1_reg   <= 1'b1;
                        err1_reg   <= illegal_reg;
                        rdata1_reg <= mem_read_reg ? memReadData : '0;
                    end else begin
                        ack0_reg   <= 1'b1;
                        err0_reg   <= illegal_reg;
                        rdata0_reg <= mem_read_reg ? memReadData : '0;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    ack0_reg  <= 1'b0;
                    ack1_reg  <= 1'b0;
                    err0_reg  <= 1'b0;
                    err1_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign ack0         = ack0_reg;
    assign ack1         = ack1_reg;
    assign err0         = err0_reg;
    assign err1         = err1_reg;
    assign rdata0       = rdata0_reg;
    assign rdata1       = rdata1_reg;
    assign memAddress   = mem_address_reg;
    assign memWriteData = mem_wdata_reg;
    assign memWrite     = mem_write_reg;
    assign memRead      = mem_read_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Drives dmem_arbiter with directed and randomized transactions and
//   compares every response against a transaction-level model: a shadow
//   memory array, the round-robin rule and the fixed three-cycle timing.
module tb_dmem_arbiter;

    localparam int MEM_SIZE = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] memAddress, memWriteData, memReadData;
    logic        memWrite, memRead, busy;

    int checks_total  = 0;
    int checks_passed = 0;

    // Data memory attached to the arbiter: synchronous write, async read.
    logic [31:0] mem [0:MEM_SIZE-1] = '{default: 32'h0};
    always @(posedge clk) begin
        if (memWrite && memAddress < 32'd256)
            mem[memAddress[7:2]] <= memWriteData;
    end
    assign memReadData = (memAddress < 32'd256) ? mem[memAddress[7:2]] : 32'h0;

    // Reference model state.
    logic [31:0] ref_mem [0:MEM_SIZE-1] = '{default: 32'h0};
    logic [31:0] exp_rdata [0:1] = '{32'h0, 32'h0};
    logic        tb_last = 1'b1;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .memAddress(memAddress), .memWriteData(memWriteData),
        .memWrite(memWrite), .memRead(memRead),
        .memReadData(memReadData), .busy(busy)
    );

    // One complete transaction starting with the DUT idle, called 1 time
    // unit after a rising edge; returns 1 time unit after the edge that
    // brings the DUT back to IDLE.
    task automatic run_txn(input logic r0, input logic r1,
                           input logic w0, input logic w1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input bit early_drop, input string name);
        logic        w, we_s, legal;
        logic [31:0] a_s, d_s, exp_rd;
        logic [6:0]  obs7, exp7;
        w      = (r0 && r1) ? ~tb_last : r1;
        tb_last = w;
        we_s   = w ? w1 : w0;
        a_s    = w ? a1 : a0;
        d_s    = w ? d1 : d0;
        legal  = (a_s[1:0] == 2'b00) && ((a_s >> 2) < MEM_SIZE);
        exp_rd = (legal && !we_s) ? ref_mem[a_s[7:2]] : 32'h0;

        req0 = r0; req1 = r1; we0 = w0; we1 = w1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;

        @(posedge clk); #1;
        // ACCESS cycle
        checks_total++;
        obs7 = {2'b00, busy, ack0, ack1, memRead, memWrite};
        exp7 = {2'b00, 1'b1, 1'b0, 1'b0, legal && !we_s, legal && we_s};
        if (obs7 !== exp7)
            $display("FAIL %s access_ctl: got %b want %b", name, obs7, exp7);
        else checks_passed++;
        if (legal) begin
            checks_total++;
            if (memAddress !== a_s || (we_s && memWriteData !== d_s))
                $display("FAIL %s access_bus: addr %h data %h want addr %h data %h",
                         name, memAddress, memWriteData, a_s, d_s);
            else checks_passed++;
        end
        if (early_drop) begin
            req0 = 1'b0; req1 = 1'b0;
            we0 = ~we0; we1 = ~we1;
            addr0 = $urandom; addr1 = $urandom;
            wdata0 = $urandom; wdata1 = $urandom;
        end

        @(posedge clk); #1;
        // RESP cycle
        exp_rdata[w] = exp_rd;
        checks_total++;
        obs7 = {busy, ack0, ack1, err0, err1, memRead, memWrite};
        exp7 = {1'b1, w == 1'b0, w == 1'b1, (w == 1'b0) && !legal,
                (w == 1'b1) && !legal, 1'b0, 1'b0};
        if (obs7 !== exp7)
            $display("FAIL %s resp_ctl: got %b want %b", name, obs7, exp7);
        else checks_passed++;
        checks_total++;
        if (rdata0 !== exp_rdata[0] || rdata1 !== exp_rdata[1] ||
            memAddress !== 32'h0 || memWriteData !== 32'h0)
            $display("FAIL %s resp_data: rdata0 %h rdata1 %h bus %h/%h want %h %h 0/0",
                     name, rdata0, rdata1, memAddress, memWriteData,
                     exp_rdata[0], exp_rdata[1]);
        else checks_passed++;
        if (legal && we_s) ref_mem[a_s[7:2]] = d_s;
        req0 = 1'b0; req1 = 1'b0;

        @(posedge clk); #1;
        // back in IDLE
        checks_total++;
        obs7 = {2'b00, busy, ack0, ack1, err0, err1};
        if (obs7 !== 7'b0 || (legal && mem[a_s[7:2]] !== ref_mem[a_s[7:2]]))
            $display("FAIL %s idle: ctl %b mem %h want 0 mem %h", name, obs7,
                     legal ? mem[a_s[7:2]] : 32'h0, legal ? ref_mem[a_s[7:2]] : 32'h0);
        else checks_passed++;
        $display("txn %-12s port%0d we=%0d addr=%h wdata=%h legal=%0d rdata=%h",
                 name, w, we_s, a_s, d_s, legal, exp_rd);
    endtask

    task automatic test_reset();
        #2;
        checks_total++;
        if ({ack0, ack1, err0, err1, memRead, memWrite, busy} !== 7'b0 ||
            rdata0 !== 32'h0 || rdata1 !== 32'h0 ||
            memAddress !== 32'h0 || memWriteData !== 32'h0)
            $display("FAIL reset_state: ctl %b rdata %h/%h bus %h/%h want all 0",
                     {ack0, ack1, err0, err1, memRead, memWrite, busy},
                     rdata0, rdata1, memAddress, memWriteData);
        else checks_passed++;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("txn reset released");
    endtask

    task automatic test_write_read();
        run_txn(1, 0, 1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0, 0, "wr0_10");
        run_txn(1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 32'h0, 0, "rd0_10");
        checks_total++;
        if (rdata0 !== 32'hDEADBEEF || mem[4] !== 32'hDEADBEEF)
            $display("FAIL write_read_value: rdata0 %h mem %h want deadbeef",
                     rdata0, mem[4]);
        else checks_passed++;
    endtask

    task automatic test_illegal();
        run_txn(0, 1, 0, 0, 32'h0, 32'h13, 32'h0, 32'h0, 0, "rd1_mis");
        run_txn(0, 1, 0, 1, 32'h0, 32'h100, 32'h0, 32'hCAFEF00D, 0, "wr1_oor");
        checks_total++;
        begin
            int diffs = 0;
            for (int i = 0; i < MEM_SIZE; i++)
                if (mem[i] !== ref_mem[i]) diffs++;
            if (diffs != 0 || rdata1 !== 32'h0)
                $display("FAIL illegal_mem: %0d words differ rdata1 %h want 0 and 0",
                         diffs, rdata1);
            else checks_passed++;
        end
    endtask

    task automatic test_round_robin();
        logic e0, e1;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tb_last = 1'b1;
        exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
        @(posedge clk); #1;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'h10; addr1 = 32'h20;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            e0 = (n % 3 == 2) && (((n - 2) / 3) % 2 == 0);
            e1 = (n % 3 == 2) && (((n - 2) / 3) % 2 == 1);
            if (e0) exp_rdata[0] = ref_mem[4];
            if (e1) exp_rdata[1] = ref_mem[8];
            checks_total++;
            if ({ack0, ack1} !== {e0, e1} || rdata0 !== exp_rdata[0] ||
                rdata1 !== exp_rdata[1])
                $display("FAIL rr_cycle%0d: ack %b rdata %h/%h want %b %h/%h", n,
                         {ack0, ack1}, rdata0, rdata1, {e0, e1},
                         exp_rdata[0], exp_rdata[1]);
            else checks_passed++;
            if (e0 || e1) $display("txn rr grant port%0d at edge %0d", e1, n);
            if (n == 11) begin req0 = 1'b0; req1 = 1'b0; end
        end
        tb_last = 1'b1;
    endtask

    task automatic test_reset_mid_access();
        run_txn(1, 0, 1, 0, 32'h08, 32'h0, 32'h0BADF00D, 32'h0, 0, "wr0_08");
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h08; wdata0 = 32'h55;
        @(posedge clk); #1;
        checks_total++;
        if (memWrite !== 1'b1)
            $display("FAIL abort_pre: memWrite %b want 1", memWrite);
        else checks_passed++;
        #3;
        rst_n = 1'b0;
        #1;
        checks_total++;
        if (memWrite !== 1'b0 || busy !== 1'b0 || memAddress !== 32'h0)
            $display("FAIL abort_drop: memWrite %b busy %b addr %h want 0 0 0",
                     memWrite, busy, memAddress);
        else checks_passed++;
        @(posedge clk); #1;
        req0 = 1'b0;
        rst_n = 1'b1;
        tb_last = 1'b1;
        exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
        @(posedge clk); #1;
        checks_total++;
        if (ack0 !== 1'b0 || mem[2] !== ref_mem[2] || rdata0 !== 32'h0)
            $display("FAIL abort_after: ack0 %b mem %h rdata0 %h want 0 %h 0",
                     ack0, mem[2], rdata0, ref_mem[2]);
        else checks_passed++;
        $display("txn abort write 0x55 to 0x08");
        run_txn(1, 0, 0, 0, 32'h08, 32'h0, 32'h0, 32'h0, 0, "rd0_08");
        checks_total++;
        if (rdata0 !== 32'h0BADF00D)
            $display("FAIL abort_readback: rdata0 %h want 0badf00d", rdata0);
        else checks_passed++;
    endtask

    task automatic test_drop_req();
        run_txn(1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 32'h0, 1, "rd0_drop");
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            checks_total++;
            if ({ack0, ack1, busy} !== 3'b000)
                $display("FAIL drop_norepeat%0d: ack/busy %b want 000", n,
                         {ack0, ack1, busy});
            else checks_passed++;
        end
    endtask

    task automatic test_random();
        logic [1:0]  r;
        logic [31:0] a [0:1];
        for (int t = 0; t < 40; t++) begin
            r = 2'($urandom_range(1, 3));
            for (int p = 0; p < 2; p++) begin
                int kind;
                kind = $urandom_range(0, 9);
                if (kind < 7)       a[p] = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                else if (kind == 7) a[p] = {24'h0, 6'($urandom_range(0, 63)),
                                            2'($urandom_range(1, 3))};
                else                a[p] = 32'h100 + 4 * $urandom_range(0, 1000);
            end
            run_txn(r[0], r[1], 1'($urandom), 1'($urandom), a[0], a[1],
                    $urandom, $urandom, $urandom_range(0, 3) == 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_illegal();
        test_round_robin();
        test_reset_mid_access();
        test_drop_req();
        test_random();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_SIZE, default 64, meaning data-memory depth in 32-bit words.
REQ-002 The block SHALL have ports clk  input  1  system clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have ports req0/req1  input  1 each  access request from requester 0/1, level.
REQ-005 The block SHALL have ports we0/we1  input  1 each  1 = write, 0 = read.
REQ-006 The block SHALL have ports addr0/addr1  input  32 each  byte address.
REQ-007 The block SHALL have ports wdata0/wdata1  input  32 each  write data.
REQ-008 The block SHALL have ports ack0/ack1  output  1 each  one-cycle completion pulse.
REQ-009 The block SHALL have ports err0/err1  output  1 each  completion-with-error flag, valid only with ack.
REQ-010 The block SHALL have ports rdata0/rdata1  output  32 each  read data, valid with ack.
REQ-011 The block SHALL have ports memAddress  output  32, memWriteData  output  32, memWrite  output  1, memRead  output  1, memReadData  input  32, which connect to the data memory (synchronous write, asynchronous read).
REQ-012 The block SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-014 In IDLE with any reqN high at a rising edge, the block SHALL latch the winner's we, addr and wdata plus its port id, and go to ACCESS.
REQ-015 Arbitration SHALL be round-robin: if both requests are high, the port not served last wins; lastGrant resets so port 0 wins the first contention.
REQ-016 With one request only, that port SHALL win regardless of lastGrant, and lastGrant SHALL update to the served port.
REQ-017 In ACCESS, for a legal latched request, memAddress SHALL equal the latched addr, and memRead SHALL be high for a read, or memWrite high with memWriteData equal to the latched wdata for a write, for exactly one cycle.
REQ-018 A request SHALL be illegal if addr[1:0] != 0 or addr>>2 >= MEM_SIZE.
REQ-019 For an illegal request, ACCESS SHALL assert neither memRead nor memWrite.
REQ-020 At the edge ending ACCESS, the block SHALL register memReadData for legal reads and 0 for writes or illegal requests, then go to RESP.
REQ-021 In RESP, ackN of the served port SHALL be high for one cycle with rdataN equal to the registered value; errN SHALL be 1 if the request was illegal; the FSM SHALL then return to IDLE.
REQ-022 Latency SHALL be fixed: request sampled at edge k produces ack during cycle k+2 (after edges k+1..k+2), and new arbitration occurs at the edge ending RESP+1 (one access per 3 cycles max).
REQ-023 rdataN SHALL hold its last value until that port's next ack; errN and ackN of the non-served port SHALL stay 0.
REQ-024 Once latched, a request SHALL NOT be cancelled by dropping reqN or changing its inputs; the requester holds reqN until ack and must drop it in the ack cycle to avoid a repeat.
REQ-025 Outside ACCESS, memRead, memWrite, memAddress and memWriteData SHALL be 0.

Reset
REQ-026 On rst_n low, the block SHALL immediately, asynchronously: state=IDLE, all ack/err=0, rdata0/rdata1=0, memRead=memWrite=0, busy=0, lastGrant=1.
REQ-027 Reset asserted during ACCESS SHALL deassert memWrite before the next edge, so no write occurs, and no ack SHALL be issued for the aborted request.

Verification
REQ-028 The bench SHALL cover: port0 write addr=0x10 data=0xDEADBEEF, then port0 read 0x10 -> memWrite one cycle with memAddress=0x10; ack0 2 cycles after sampling; read returns rdata0=0xDEADBEEF, err0=0.
REQ-029 The bench SHALL cover: req0 and req1 both held for reads from reset -> grants alternate 0,1,0,1; each ack 3 cycles apart; never both acks high.
REQ-030 The bench SHALL cover: port1 read addr=0x13 (misaligned), and port1 write addr=0x100 with MEM_SIZE=64 -> no memRead/memWrite; ack1=1, err1=1, rdata1=0; memory unchanged.
REQ-031 The bench SHALL cover: rst_n pulled low mid-ACCESS of a write 0x55 to 0x08 -> memWrite drops immediately; a later read of 0x08 returns the prior value; no ack.
REQ-032 The bench SHALL cover: req0 dropped one cycle after being sampled -> access still completes, with ack0 pulsed once.
